// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM unified-memory port arbiter: FSM state
// encodings, owner codes, DMType codes and the timeout poison word.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StGrantIf = 2'd1,
        StGrantDm = 2'd2,
        StResp    = 2'd3
    } arb_state_e;

    typedef enum logic {
        OwnerIf = 1'b0,
        OwnerDm = 1'b1
    } owner_e;

    // DMType codes as used by the core's data-memory control.
    localparam logic [2:0] DmWord         = 3'b000;
    localparam logic [2:0] DmHalfword     = 3'b001;
    localparam logic [2:0] DmHalfwordUns  = 3'b010;
    localparam logic [2:0] DmByte         = 3'b011;
    localparam logic [2:0] DmByteUns      = 3'b100;

    // Read data returned to the owner when the watchdog abandons an access.
    localparam logic [31:0] TimeoutPoison = 32'hDEADBEEF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core (IF and MEM stages), the arbiter and the
// unified memory. The arbiter uses the slave view; the core/memory side
// (or a testbench) uses the master view.
interface mem_port_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [2:0]  dm_type;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_type;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic        stall_if;
    logic        stall_mem;
    logic        timeout_err;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_type,
        input  mem_ready, mem_rdata,
        output if_ack, if_rdata,
        output dm_ack, dm_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_type,
        output stall_if, stall_mem, timeout_err
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_type,
        output mem_ready, mem_rdata,
        input  if_ack, if_rdata,
        input  dm_ack, dm_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_type,
        input  stall_if, stall_mem, timeout_err
    );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Watchdog for a memory access that never completes. Counts cycles with
// mem_req high and mem_ready low; fires expire on the TIMEOUT_CYCLES-th such
// cycle and keeps a sticky error flag. Only built with MEM_ARB_TIMEOUT_EN.
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mem_req,
    input  logic mem_ready,
    output logic expire,
    output logic timeout_err
);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            waiting;

    assign waiting     = mem_req & ~mem_ready;
    assign expire      = waiting & (cnt_q == CntLast);
    assign timeout_err = err_q;

    // Count stalled cycles; restart whenever the access completes or is abandoned.
    always_comb begin
        cnt_d = '0;
        err_d = err_q | expire;
        if (waiting && !expire) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Counter and sticky flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port, variable-latency memory between the IF
// and MEM pipeline stages. DM has priority, but after DM_BURST_MAX DM grants
// with a fetch pending the fetch gets one forced grant.
// Optional feature: define MEM_ARB_TIMEOUT_EN to add a watchdog that aborts
// stuck accesses with poison read data and a sticky timeout_err.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned DM_BURST_MAX = 4
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned BurstW = $clog2(DM_BURST_MAX + 1);
    localparam logic [BurstW-1:0] BurstMax = BurstW'(DM_BURST_MAX);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [BurstW-1:0] burst_q, burst_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [2:0]        mem_type_q, mem_type_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       dm_rdata_q, dm_rdata_d;

    logic mem_req;
    logic grant_if;
    logic wd_expire;
    logic timeout_err;

    assign mem_req  = (state_q == StGrantIf) || (state_q == StGrantDm);
    // IF wins only when DM is idle or DM has used up its burst allowance.
    assign grant_if = bus.if_req & (~bus.dm_req | (burst_q == BurstMax));

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_req    (mem_req),
        .mem_ready  (bus.mem_ready),
        .expire     (wd_expire),
        .timeout_err(timeout_err)
    );
`else
    assign wd_expire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next-state: grant in IDLE, wait for memory in GRANT_x, ack for one cycle in RESP.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        burst_d     = burst_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_type_d  = mem_type_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (grant_if) begin
                    state_d     = StGrantIf;
                    owner_d     = OwnerIf;
                    burst_d     = '0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                    mem_type_d  = DmWord;
                end else if (bus.dm_req) begin
                    state_d     = StGrantDm;
                    owner_d     = OwnerDm;
                    mem_we_d    = bus.dm_we;
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                    mem_type_d  = bus.dm_type;
                    // Only DM grants that starve a pending fetch count toward the burst.
                    if (!bus.if_req) begin
                        burst_d = '0;
                    end else if (burst_q != BurstMax) begin
                        burst_d = burst_q + BurstW'(1);
                    end
                end
            end
            StGrantIf, StGrantDm: begin
                if (bus.mem_ready) begin
                    state_d = StResp;
                    if (owner_q == OwnerIf) begin
                        if_rdata_d = bus.mem_rdata;
                    end else if (!mem_we_q) begin
                        dm_rdata_d = bus.mem_rdata;
                    end
                end else if (wd_expire) begin
                    state_d = StResp;
                    if (owner_q == OwnerIf) begin
                        if_rdata_d = TimeoutPoison;
                    end else begin
                        dm_rdata_d = TimeoutPoison;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and payload registers; reset drops mem_req and acks immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            owner_q     <= OwnerIf;
            burst_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_type_q  <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            burst_q     <= burst_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_type_q  <= mem_type_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign bus.mem_req     = mem_req;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_type    = mem_type_q;
    assign bus.if_ack      = (state_q == StResp) && (owner_q == OwnerIf);
    assign bus.dm_ack      = (state_q == StResp) && (owner_q == OwnerDm);
    assign bus.if_rdata    = if_rdata_q;
    assign bus.dm_rdata    = dm_rdata_q;
    // Stalls are forced low during reset so the pipeline is released at once.
    assign bus.stall_if    = rst_n & bus.if_req & ~bus.if_ack;
    assign bus.stall_mem   = rst_n & bus.dm_req & ~bus.dm_ack;
    assign bus.timeout_err = timeout_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter. Inputs change and
// outputs are sampled 2 time units after each rising clock edge.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    bit owner_seq [7];
    int k;

    initial begin
        rst_n         = 1'b0;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.dm_req    = 1'b0;
        bus.dm_we     = 1'b0;
        bus.dm_addr   = '0;
        bus.dm_wdata  = '0;
        bus.dm_type   = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        owner_seq     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        // Reset state
        #3;
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_if_ack", bus.if_ack, 0);
        chk("rst_dm_ack", bus.dm_ack, 0);
        chk("rst_stall_if", bus.stall_if, 0);
        chk("rst_stall_mem", bus.stall_mem, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_dm_rdata", bus.dm_rdata, 0);
        chk("rst_timeout_err", bus.timeout_err, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1: single fetch, minimum latency
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        #1;
        chk("t1_stall_if_req", bus.stall_if, 1);
        tick();
        chk("t1_mem_req_c1", bus.mem_req, 1);
        chk("t1_mem_addr", bus.mem_addr, 32'h100);
        chk("t1_mem_we", bus.mem_we, 0);
        chk("t1_mem_type", bus.mem_type, 0);
        chk("t1_if_ack_c1", bus.if_ack, 0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0000_0013;
        tick();
        chk("t1_mem_req_c2", bus.mem_req, 0);
        chk("t1_if_ack_c2", bus.if_ack, 1);
        chk("t1_if_rdata", bus.if_rdata, 32'h0000_0013);
        chk("t1_stall_if_ack", bus.stall_if, 0);
        chk("t1_dm_ack", bus.dm_ack, 0);
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        tick();
        chk("t1_if_ack_c3", bus.if_ack, 0);
        chk("t1_mem_req_c3", bus.mem_req, 0);

        // 2: simultaneous IF and DM load, DM first
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h104;
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 32'h2000;
        bus.dm_type = 3'b010;
        #1;
        chk("t2_stall_if_0", bus.stall_if, 1);
        chk("t2_stall_mem_0", bus.stall_mem, 1);
        tick();
        chk("t2_mem_addr_dm", bus.mem_addr, 32'h2000);
        chk("t2_mem_type_dm", bus.mem_type, 3'b010);
        chk("t2_stall_if_1", bus.stall_if, 1);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h1111_2222;
        tick();
        chk("t2_dm_ack", bus.dm_ack, 1);
        chk("t2_if_ack_dm", bus.if_ack, 0);
        chk("t2_dm_rdata", bus.dm_rdata, 32'h1111_2222);
        chk("t2_if_rdata_kept", bus.if_rdata, 32'h0000_0013);
        chk("t2_stall_if_2", bus.stall_if, 1);
        chk("t2_stall_mem_2", bus.stall_mem, 0);
        bus.dm_req    = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        chk("t2_mem_req_idle", bus.mem_req, 0);
        chk("t2_stall_if_3", bus.stall_if, 1);
        tick();
        chk("t2_mem_addr_if", bus.mem_addr, 32'h104);
        chk("t2_mem_type_if", bus.mem_type, 0);
        chk("t2_stall_if_4", bus.stall_if, 1);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0000_0022;
        tick();
        chk("t2_if_ack", bus.if_ack, 1);
        chk("t2_if_rdata", bus.if_rdata, 32'h0000_0022);
        chk("t2_dm_rdata_kept", bus.dm_rdata, 32'h1111_2222);
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b0;
        tick();

        // 3: DM burst of 6 loads with a fetch pending; IF forced after 4 DM grants
        k            = 0;
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b0;
        bus.dm_type  = 3'b000;
        bus.dm_addr  = 32'h3000;
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h300;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("t3_mem_req", bus.mem_req, 1);
            chk("t3_mem_addr", bus.mem_addr,
                owner_seq[i] ? 32'h3000 + 32'(4 * k) : 32'h300);
            bus.mem_ready = 1'b1;
            bus.mem_rdata = 32'hA000_0000 + 32'(i);
            tick();
            bus.mem_ready = 1'b0;
            if (owner_seq[i]) begin
                chk("t3_dm_ack", bus.dm_ack, 1);
                chk("t3_if_ack_on_dm", bus.if_ack, 0);
                chk("t3_dm_rdata", bus.dm_rdata, 32'hA000_0000 + 32'(i));
                k++;
                if (k == 6) begin
                    bus.dm_req = 1'b0;
                end else begin
                    bus.dm_addr = 32'h3000 + 32'(4 * k);
                end
            end else begin
                chk("t3_if_ack", bus.if_ack, 1);
                chk("t3_dm_ack_on_if", bus.dm_ack, 0);
                chk("t3_if_rdata", bus.if_rdata, 32'hA000_0000 + 32'(i));
                bus.if_req = 1'b0;
            end
            tick();
        end

        // 4: store with 3 wait cycles
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_addr  = 32'h4000;
        bus.dm_wdata = 32'hCAFE_F00D;
        bus.dm_type  = 3'b000;
        tick();
        for (int j = 0; j < 3; j++) begin
            chk("t4_mem_req_wait", bus.mem_req, 1);
            chk("t4_mem_we", bus.mem_we, 1);
            chk("t4_mem_wdata", bus.mem_wdata, 32'hCAFE_F00D);
            chk("t4_dm_ack_wait", bus.dm_ack, 0);
            chk("t4_stall_mem", bus.stall_mem, 1);
            tick();
        end
        chk("t4_mem_req_rdy", bus.mem_req, 1);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h5555_5555;
        tick();
        chk("t4_dm_ack", bus.dm_ack, 1);
        chk("t4_dm_rdata_kept", bus.dm_rdata, 32'hA000_0006);
        chk("t4_mem_req_done", bus.mem_req, 0);
        bus.dm_req    = 1'b0;
        bus.dm_we     = 1'b0;
        bus.mem_ready = 1'b0;
        tick();

        // 5: reset in the middle of a fetch
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h500;
        tick();
        chk("t5_mem_req_pre", bus.mem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_mem_req_rst", bus.mem_req, 0);
        chk("t5_stall_if_rst", bus.stall_if, 0);
        chk("t5_if_ack_rst", bus.if_ack, 0);
        chk("t5_mem_addr_rst", bus.mem_addr, 0);
        chk("t5_if_rdata_rst", bus.if_rdata, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("t5_stall_if_rel", bus.stall_if, 1);
        chk("t5_mem_req_rel", bus.mem_req, 0);
        tick();
        chk("t5_mem_req_new", bus.mem_req, 1);
        chk("t5_mem_addr_new", bus.mem_addr, 32'h500);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0000_0077;
        tick();
        chk("t5_if_ack", bus.if_ack, 1);
        chk("t5_if_rdata", bus.if_rdata, 32'h0000_0077);
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b0;
        tick();

`ifdef MEM_ARB_TIMEOUT_EN
        // 6: memory never answers; watchdog aborts after 255 stalled cycles
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h600;
        tick();
        for (int c = 0; c < 255; c++) begin
            if (c == 0 || c == 254) begin
                chk("t6_mem_req_wait", bus.mem_req, 1);
                chk("t6_if_ack_wait", bus.if_ack, 0);
                chk("t6_err_wait", bus.timeout_err, 0);
            end
            tick();
        end
        chk("t6_if_ack", bus.if_ack, 1);
        chk("t6_if_rdata", bus.if_rdata, 32'hDEAD_BEEF);
        chk("t6_err", bus.timeout_err, 1);
        chk("t6_mem_req_drop", bus.mem_req, 0);
        bus.if_req = 1'b0;
        tick();
        tick();
        chk("t6_err_sticky", bus.timeout_err, 1);
`else
        chk("timeout_err_off", bus.timeout_err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
